// File: rtl/instr_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/BRANCH walk, run/halt, retire count.
// Optional single-step input is enabled by defining SINGLE_STEP_EN.
module instr_seq_ctrl #(
    parameter int unsigned ROM_LAT = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             halt_req,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [31:0]      IR,
    input  logic             W_IR_valid,
    input  logic             mem_ready,
    output logic             write_pc,
    output logic             write_ir,
    output logic [1:0]       pc_s,
    output logic             rf_we,
    output logic             nzcv_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        BRANCH = 3'd6,
        TRAP   = 3'd7
    } state_t;

    localparam int unsigned    LAT_W    = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ROM_LAT);

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         pc_sel_q, pc_sel_d;
    logic               is_ls_q, is_ls_d;
    logic               step_mode_q, step_mode_d;
    logic               retire;
    logic               enter_fetch;
    logic               is_bx;
    logic               unused_ir;

    assign is_bx     = (IR[27:4] == 24'h12FFF1);
    assign unused_ir = ^{IR[31:28], IR[3:0]};

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        cnt_d       = cnt_q;
        pc_sel_d    = pc_sel_q;
        is_ls_d     = is_ls_q;
        step_mode_d = step_mode_q;
        retire      = 1'b0;
        enter_fetch = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    enter_fetch = 1'b1;
                    step_mode_d = 1'b0;
                end
`ifdef SINGLE_STEP_EN
                else if (step) begin
                    enter_fetch = 1'b1;
                    step_mode_d = 1'b1;
                end
`endif
            end
            FETCH: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - LAT_W'(1);
                end else if (W_IR_valid) begin
                    state_d = DECODE;
                end else begin
                    // Condition-failed instruction is retired without executing.
                    retire      = 1'b1;
                    enter_fetch = 1'b1;
                end
            end
            DECODE: begin
                if (is_bx) begin
                    state_d  = BRANCH;
                    pc_sel_d = 2'b10;
                end else begin
                    case (IR[27:26])
                        2'b00: begin
                            state_d = EXEC;
                            is_ls_d = 1'b0;
                        end
                        2'b01: begin
                            state_d = EXEC;
                            is_ls_d = 1'b1;
                        end
                        2'b10: begin
                            state_d  = BRANCH;
                            pc_sel_d = 2'b01;
                        end
                        default: state_d = TRAP;
                    endcase
                end
            end
            EXEC: state_d = is_ls_q ? MEM : WB;
            MEM: begin
                if (mem_ready) begin
                    if (IR[20]) begin
                        state_d = WB;
                    end else begin
                        retire      = 1'b1;
                        enter_fetch = 1'b1;
                    end
                end
            end
            WB, BRANCH: begin
                retire      = 1'b1;
                enter_fetch = 1'b1;
            end
            default: state_d = TRAP;
        endcase

        if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Every instruction boundary is where halt and single-step take effect.
        if (enter_fetch) begin
            if (halt_req || (retire && step_mode_q)) begin
                state_d = IDLE;
            end else begin
                state_d = FETCH;
                wait_d  = LAT_LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            cnt_q       <= '0;
            pc_sel_q    <= 2'b00;
            is_ls_q     <= 1'b0;
            step_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            cnt_q       <= cnt_d;
            pc_sel_q    <= pc_sel_d;
            is_ls_q     <= is_ls_d;
            step_mode_q <= step_mode_d;
        end
    end

    // Strobes depend only on registered state plus the stable IR from fetch.
    always_comb begin
        write_pc = 1'b0;
        write_ir = 1'b0;
        pc_s     = 2'b00;
        rf_we    = 1'b0;
        nzcv_we  = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            FETCH: begin
                if (wait_q == '0) begin
                    write_pc = 1'b1;
                    write_ir = 1'b1;
                end
            end
            EXEC: nzcv_we = ~is_ls_q & IR[20];
            MEM: begin
                mem_re = IR[20];
                mem_we = ~IR[20];
            end
            WB: rf_we = ~(~is_ls_q & (IR[24:23] == 2'b10) & IR[20]);
            BRANCH: begin
                write_pc = 1'b1;
                pc_s     = pc_sel_q;
                rf_we    = IR[24];
            end
            default: ;
        endcase
    end

    assign halted    = (state_q == IDLE) || (state_q == TRAP);
    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule
